// File: rtl/adder_result_stage.sv
// Registered result stage for an adder: output register plus one skid entry, NZCV flag capture.
// Optional sticky overflow flag and saturating overflow counter when ADDER_STICKY_OVF_EN is defined.
module adder_result_stage #(
    parameter int size = 32
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [size-1:0] SUM,
    input  logic            COUT,
    input  logic            OVF,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [size-1:0] RESULT,
    output logic [3:0]      FLAGS
`ifdef ADDER_STICKY_OVF_EN
    ,
    input  logic            CLR_STICKY,
    output logic            STICKY_V,
    output logic [7:0]      OVF_COUNT
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    logic            skid_valid;
    logic [size-1:0] skid_sum;
    logic [3:0]      skid_flags;
    logic [3:0]      in_flags;
    logic            accept;
    logic            xfer;
    logic            out_free;

    assign in_flags = {SUM[size-1], (SUM == '0), COUT, OVF};
    assign IN_READY = ~skid_valid;
    assign accept   = IN_VALID & IN_READY;
    assign xfer     = OUT_VALID & OUT_READY;
    assign out_free = ~OUT_VALID | OUT_READY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUT_VALID  <= 1'b0;
            RESULT     <= '0;
            FLAGS      <= 4'b0000;
            skid_valid <= 1'b0;
            skid_sum   <= '0;
            skid_flags <= 4'b0000;
        end else if (out_free) begin
            // The skid can only be occupied while the output register is full,
            // so draining it always has priority over a new input.
            if (skid_valid) begin
                RESULT     <= skid_sum;
                FLAGS      <= skid_flags;
                OUT_VALID  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                RESULT    <= SUM;
                FLAGS     <= in_flags;
                OUT_VALID <= 1'b1;
            end else begin
                OUT_VALID <= 1'b0;
            end
        end else if (accept) begin
            skid_sum   <= SUM;
            skid_flags <= in_flags;
            skid_valid <= 1'b1;
        end
    end

`ifdef ADDER_STICKY_OVF_EN
    logic [7:0] count_base;
    logic [7:0] count_next;
    logic       sticky_next;

    // Clear first, then count, so a clear coinciding with an overflow transfer leaves 1.
    always_comb begin
        count_base  = CLR_STICKY ? 8'd0 : OVF_COUNT;
        sticky_next = CLR_STICKY ? 1'b0 : STICKY_V;
        count_next  = count_base;
        if (xfer && FLAGS[0]) begin
            sticky_next = 1'b1;
            if (count_base != 8'hFF) begin
                count_next = count_base + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            STICKY_V  <= 1'b0;
            OVF_COUNT <= 8'd0;
        end else begin
            STICKY_V  <= sticky_next;
            OVF_COUNT <= count_next;
        end
    end
`endif

endmodule

// File: tb/tb_adder_result_stage.sv
// Self-checking bench for adder_result_stage: directed scenarios plus randomized traffic
// against a queue-based model of the two-entry stage.
module tb_adder_result_stage;
    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;
`ifdef ADDER_STICKY_OVF_EN
    logic         clr_sticky;
    logic         sticky_v;
    logic [7:0]   ovf_count;
    int           m_cnt;
    logic         m_sticky;
`endif

    int n_cmp;
    int n_err;

    // Model: entries held by the stage, oldest first, as {flags, sum}.
    logic [W+3:0] exp_q[$];
    logic [W+3:0] last_out;

    adder_result_stage #(.size(W)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .SUM       (sum),
        .COUT      (cout),
        .OVF       (ovf),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .RESULT    (result),
        .FLAGS     (flags)
`ifdef ADDER_STICKY_OVF_EN
        ,
        .CLR_STICKY(clr_sticky),
        .STICKY_V  (sticky_v),
        .OVF_COUNT (ovf_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [W+3:0] make_entry(input logic [W-1:0] s, input logic c, input logic o);
        logic n;
        logic z;
        n = (s >= 32'h8000_0000);
        z = (s == 0);
        return {n, z, c, o, s};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        last_out = '0;
`ifdef ADDER_STICKY_OVF_EN
        m_cnt    = 0;
        m_sticky = 1'b0;
`endif
    endtask

    // Driver: called just after a falling edge; applies inputs for one clock and
    // advances the model, returning at the next falling edge.
    task automatic drive_cycle(input logic iv, input logic [W-1:0] s, input logic c,
                               input logic o, input logic ordy, input logic clr);
        logic acc;
        logic xf;
        logic [W+3:0] ent;
        in_valid  = iv;
        sum       = s;
        cout      = c;
        ovf       = o;
        out_ready = ordy;
`ifdef ADDER_STICKY_OVF_EN
        clr_sticky = clr;
`endif
        acc = iv && in_ready;
        xf  = out_valid && ordy;
        @(posedge clk);
`ifdef ADDER_STICKY_OVF_EN
        if (clr) begin
            m_cnt    = 0;
            m_sticky = 1'b0;
        end
`endif
        if (xf && exp_q.size() > 0) begin
            ent      = exp_q.pop_front();
            last_out = ent;
`ifdef ADDER_STICKY_OVF_EN
            if (ent[W]) begin
                m_sticky = 1'b1;
                if (m_cnt < 255) m_cnt = m_cnt + 1;
            end
`else
            if (clr) last_out = ent;
`endif
        end
        if (acc) exp_q.push_back(make_entry(s, c, o));
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b0; sum = '0; cout = 1'b0; ovf = 1'b0; out_ready = 1'b0;
`ifdef ADDER_STICKY_OVF_EN
        clr_sticky = 1'b0;
`endif
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({out_valid, in_ready, result, flags} !== {1'b0, 1'b1, 32'h0, 4'h0}) begin
            n_err++;
            $display("FAIL reset_initial: got v=%b r=%b res=%h f=%b, want v=0 r=1 res=0 f=0",
                     out_valid, in_ready, result, flags);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Fill both entries with the consumer stalled, then reset between edges.
        drive_cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_prefill: got v=%b r=%b, want v=1 r=0", out_valid, in_ready);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, in_ready, result, flags} !== {1'b0, 1'b1, 32'h0, 4'h0}) begin
            n_err++;
            $display("FAIL reset_async: got v=%b r=%b res=%h f=%b, want v=0 r=1 res=0 f=0",
                     out_valid, in_ready, result, flags);
        end
`ifdef ADDER_STICKY_OVF_EN
        n_cmp++;
        if ({sticky_v, ovf_count} !== 9'h0) begin
            n_err++;
            $display("FAIL reset_sticky: got s=%b cnt=%0d, want 0 0", sticky_v, ovf_count);
        end
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({out_valid, result} !== {1'b1, 32'h0000_1234}) begin
            n_err++;
            $display("FAIL reset_first_accept: got v=%b res=%h, want v=1 res=00001234", out_valid, result);
        end
        drain();
    endtask

    task automatic test_single();
        drive_cycle(1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({out_valid, result, flags} !== {1'b1, 32'h0, 4'b0110}) begin
            n_err++;
            $display("FAIL single_zero: got v=%b res=%h f=%b, want v=1 res=0 f=0110", out_valid, result, flags);
        end
        drain();
    endtask

    task automatic test_ovf();
        drive_cycle(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if ({out_valid, result, flags} !== {1'b1, 32'h8000_0000, 4'b1001}) begin
            n_err++;
            $display("FAIL signed_ovf: got v=%b res=%h f=%b, want v=1 res=80000000 f=1001", out_valid, result, flags);
        end
        drain();
        n_cmp++;
        if ({out_valid, result, flags} !== {1'b0, 32'h8000_0000, 4'b1001}) begin
            n_err++;
            $display("FAIL retain_idle: got v=%b res=%h f=%b, want v=0 res=80000000 f=1001", out_valid, result, flags);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] want[3];
        want[0] = 32'h1111_1111; want[1] = 32'h2222_2222; want[2] = 32'h3333_3333;
        drive_cycle(1'b1, want[0], 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, want[1], 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({in_ready, out_valid, result} !== {1'b0, 1'b1, want[0]}) begin
            n_err++;
            $display("FAIL bp_full: got r=%b v=%b res=%h, want r=0 v=1 res=%h", in_ready, out_valid, result, want[0]);
        end
        drive_cycle(1'b1, want[2], 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({in_ready, result, exp_q.size()} !== {1'b0, want[0], 32'd2}) begin
            n_err++;
            $display("FAIL bp_hold: got r=%b res=%h held=%0d, want r=0 res=%h held=2",
                     in_ready, result, exp_q.size(), want[0]);
        end
        for (int i = 1; i < 3; i++) begin
            drive_cycle(1'b1, want[2], 1'b0, 1'b0, 1'b1, 1'b0);
            n_cmp++;
            if ({out_valid, result} !== {1'b1, want[i]}) begin
                n_err++;
                $display("FAIL bp_order_%0d: got v=%b res=%h, want v=1 res=%h", i, out_valid, result, want[i]);
            end
        end
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({out_valid, in_ready, result} !== {1'b0, 1'b1, want[2]}) begin
            n_err++;
            $display("FAIL bp_empty: got v=%b r=%b res=%h, want v=0 r=1 res=%h", out_valid, in_ready, result, want[2]);
        end
    endtask

    task automatic test_streaming();
        logic [W-1:0] s;
        for (int i = 0; i < 10; i++) begin
            s = $urandom;
            drive_cycle(1'b1, s, 1'b0, 1'b0, 1'b1, 1'b0);
            n_cmp++;
            if ({out_valid, in_ready, result} !== {1'b1, 1'b1, s}) begin
                n_err++;
                $display("FAIL stream_%0d: got v=%b r=%b res=%h, want v=1 r=1 res=%h", i, out_valid, in_ready, result, s);
            end
        end
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stream_end: got v=%b, want v=0", out_valid);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] s;
        logic [W+3:0] want;
        logic clr;
        for (int i = 0; i < 400; i++) begin
            s = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
            clr = ($urandom_range(0, 15) == 0);
            drive_cycle($urandom_range(0, 3) != 0, s, 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0, clr);
            want = (exp_q.size() > 0) ? exp_q[0] : last_out;
            n_cmp++;
            if ({out_valid, in_ready, flags, result} !== {exp_q.size() > 0, exp_q.size() < 2, want}) begin
                n_err++;
                $display("FAIL random_%0d: got v=%b r=%b f/res=%h, want v=%b r=%b f/res=%h", i,
                         out_valid, in_ready, {flags, result}, exp_q.size() > 0, exp_q.size() < 2, want);
            end
`ifdef ADDER_STICKY_OVF_EN
            n_cmp++;
            if ({sticky_v, ovf_count} !== {m_sticky, 8'(m_cnt)}) begin
                n_err++;
                $display("FAIL random_sticky_%0d: got s=%b cnt=%0d, want s=%b cnt=%0d", i,
                         sticky_v, ovf_count, m_sticky, m_cnt);
            end
`endif
        end
        drain();
    endtask

`ifdef ADDER_STICKY_OVF_EN
    task automatic test_sticky();
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, $urandom, 1'b0, 1'b1, 1'b1, 1'b0);
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({sticky_v, ovf_count} !== {1'b1, 8'd3}) begin
            n_err++;
            $display("FAIL sticky_three: got s=%b cnt=%0d, want s=1 cnt=3", sticky_v, ovf_count);
        end
        drive_cycle(1'b1, $urandom, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if ({sticky_v, ovf_count} !== {1'b1, 8'd1}) begin
            n_err++;
            $display("FAIL sticky_clr_with_v: got s=%b cnt=%0d, want s=1 cnt=1", sticky_v, ovf_count);
        end
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if ({sticky_v, ovf_count} !== {1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL sticky_clear: got s=%b cnt=%0d, want s=0 cnt=0", sticky_v, ovf_count);
        end
        for (int i = 0; i < 300; i++) drive_cycle(1'b1, $urandom, 1'b1, 1'b1, 1'b1, 1'b0);
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({sticky_v, ovf_count, m_cnt} !== {1'b1, 8'd255, 32'd255}) begin
            n_err++;
            $display("FAIL sticky_saturate: got s=%b cnt=%0d, want s=1 cnt=255 (model %0d)",
                     sticky_v, ovf_count, m_cnt);
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_ovf();
        test_backpressure();
        test_streaming();
        test_random();
`ifdef ADDER_STICKY_OVF_EN
        test_sticky();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
